// File: rtl/inv_mixcol_seq_if.sv
// Handshake bundle for the iterative InvMixColumns engine.
// Optional INV_MIXCOL_FWD_EN adds the fwd mode-select signal.
interface inv_mixcol_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
`ifdef INV_MIXCOL_FWD_EN
  logic         fwd;

  modport master (output in_valid, in_data, out_ready, fwd,
                  input  in_ready, out_valid, out_data, busy);
  modport slave  (input  in_valid, in_data, out_ready, fwd,
                  output in_ready, out_valid, out_data, busy);
`else
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, busy);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, busy);
`endif
endinterface

// File: rtl/inv_mixcol_seq.sv
// Iterative AES InvMixColumns: COLS_PER_CYCLE columns per clock, in place.
// Optional INV_MIXCOL_FWD_EN: fwd=1 applies forward MixColumns instead.
module inv_mixcol_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  inv_mixcol_seq_if.slave bus
);
  localparam int N = COLS_PER_CYCLE;

  generate
    if (N != 1 && N != 2 && N != 4) begin : g_bad_cfg
      $error("inv_mixcol_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q;
  logic [1:0]           col_cnt_q;
  // Packed so work_q[3] is column 0 (bits 127:96) and column c is work_q[~c].
  logic [3:0][31:0]     work_q, work_d;
  logic                 out_valid_q;
  logic [127:0]         out_data_q;
`ifdef INV_MIXCOL_FWD_EN
  logic                 fwd_q;
`endif
  logic [N-1:0][1:0]    lane_col;
  logic [N-1:0][31:0]   lane_out;
  logic                 last_grp;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One output byte: 0e*a ^ 0b*b ^ 0d*c ^ 09*d from the 2x/4x/8x chain.
  function automatic logic [7:0] inv_row(input logic [7:0] a, b, c, d);
    return (xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a))
         ^ (xt(xt(xt(b))) ^ xt(b) ^ b)
         ^ (xt(xt(xt(c))) ^ xt(xt(c)) ^ c)
         ^ (xt(xt(xt(d))) ^ d);
  endfunction

  // Rows are the same polynomial applied to rotated column bytes.
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {inv_row(a0, a1, a2, a3), inv_row(a1, a2, a3, a0),
            inv_row(a2, a3, a0, a1), inv_row(a3, a0, a1, a2)};
  endfunction

`ifdef INV_MIXCOL_FWD_EN
  function automatic logic [7:0] fwd_row(input logic [7:0] a, b, c, d);
    return xt(a) ^ xt(b) ^ b ^ c ^ d;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic f);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    if (f)
      return {fwd_row(a0, a1, a2, a3), fwd_row(a1, a2, a3, a0),
              fwd_row(a2, a3, a0, a1), fwd_row(a3, a0, a1, a2)};
    return inv_col(c);
  endfunction
`endif

  // Lane l handles column col_cnt+l; 2-bit wrap keeps it in 0..3.
  generate
    for (genvar l = 0; l < N; l++) begin : g_lane
      assign lane_col[l] = col_cnt_q + 2'(l);
`ifdef INV_MIXCOL_FWD_EN
      assign lane_out[l] = mix_col(work_q[~lane_col[l]], fwd_q);
`else
      assign lane_out[l] = inv_col(work_q[~lane_col[l]]);
`endif
    end
  endgenerate

  assign last_grp = (col_cnt_q == 2'(4 - N));

  // Merge the freshly transformed lane columns back into the work register.
  always_comb begin
    work_d = work_q;
    for (int l = 0; l < N; l++)
      work_d[~lane_col[l]] = lane_out[l];
  end

  // Control FSM with registered result/valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_cnt_q   <= 2'd0;
      work_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef INV_MIXCOL_FWD_EN
      fwd_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          work_q    <= bus.in_data;
          col_cnt_q <= 2'd0;
`ifdef INV_MIXCOL_FWD_EN
          fwd_q     <= bus.fwd;
`endif
          state_q   <= BUSY;
        end
        BUSY: begin
          work_q    <= work_d;
          col_cnt_q <= col_cnt_q + 2'(N);
          if (last_grp) begin
            out_data_q  <= work_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = rst_n && (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_inv_mixcol_seq.sv
// Bench for inv_mixcol_seq: one instance each of N=1, 2, 4 sharing clk/rst.
module tb_inv_mixcol_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]   in_valid = '0;
  logic [2:0]   out_ready = '0;
  logic [127:0] in_data = '0;
  bit           fwd_r = 1'b0;
  wire  [2:0]   in_ready_w, out_valid_w, busy_w;
  wire  [127:0] out_data_w [3];

  int pass_cnt = 0;
  int total = 0;

  localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] E2 = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;

  generate
    for (genvar k = 0; k < 3; k++) begin : g
      inv_mixcol_seq_if bus();
      assign bus.in_valid  = in_valid[k];
      assign bus.in_data   = in_data;
      assign bus.out_ready = out_ready[k];
`ifdef INV_MIXCOL_FWD_EN
      assign bus.fwd       = fwd_r;
`endif
      assign in_ready_w[k]  = bus.in_ready;
      assign out_valid_w[k] = bus.out_valid;
      assign busy_w[k]      = bus.busy;
      assign out_data_w[k]  = bus.out_data;
      inv_mixcol_seq #(.COLS_PER_CYCLE(1 << k)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
      );
    end
  endgenerate

  // Generic GF(2^8) multiply, shift-and-add with the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // Column-wise matrix product; row r uses the coefficient row rotated by r.
  function automatic logic [127:0] ref_mix(input logic [127:0] d, input bit f);
    logic [7:0] m [4];
    logic [7:0] b [16];
    logic [7:0] acc;
    logic [127:0] r = '0;
    if (f) begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
    else   begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
    for (int k = 0; k < 16; k++) b[k] = 8'(d >> (8 * (15 - k)));
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[(j - i + 4) % 4], b[4*c + j]);
        r = (r << 8) | 128'(acc);
      end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  // Bounded wait for in_ready on instance k.
  task automatic wait_rdy(input int k, input string tag);
    int t = 0;
    while (!in_ready_w[k] && t < 20) begin step(); t++; end
    chk({tag, "_rdy"}, 128'(in_ready_w[k]), 128'd1);
  endtask

  // Counts edges after the accepting edge until out_valid, bounded.
  task automatic wait_out(input int k, input string tag);
    int lat = 0;
    while (!out_valid_w[k] && lat < 20) begin step(); lat++; end
    chk({tag, "_lat"}, 128'(lat), 128'(4 >> k));
  endtask

  task automatic run_txn(input int k, input logic [127:0] d, input bit f,
                         input logic [127:0] exp, input string tag);
    in_data = d; fwd_r = f; in_valid[k] = 1'b1; out_ready[k] = 1'b1;
    wait_rdy(k, tag);
    step();                    // accepting edge
    in_valid[k] = 1'b0;
    chk({tag, "_busy"}, 128'(busy_w[k]), 128'd1);
    wait_out(k, tag);
    chk({tag, "_data"}, out_data_w[k], exp);
    step();                    // output handshake edge
    chk({tag, "_vld_clr"}, 128'(out_valid_w[k]), 128'd0);
    chk({tag, "_rdy_back"}, 128'(in_ready_w[k]), 128'd1);
  endtask

  initial begin
    logic [127:0] a, b;
    int k;
    bit f;

    // Reset state, including in_ready held low while rst_n=0.
    step(); step();
    for (int i = 0; i < 3; i++) begin
      chk("rst_vld", 128'(out_valid_w[i]), 128'd0);
      chk("rst_data", out_data_w[i], 128'd0);
      chk("rst_busy", 128'(busy_w[i]), 128'd0);
      chk("rst_rdy", 128'(in_ready_w[i]), 128'd0);
    end
    rst_n = 1'b1;
    step();

    // Directed vectors: N=1, then N=2 and N=4 sweep.
    run_txn(0, V1, 1'b0, E1, "n1_vec");
    run_txn(1, V2, 1'b0, E2, "n2_vec");
    run_txn(2, V2, 1'b0, E2, "n4_vec");

    // Backpressure on N=1 with in_valid held high throughout.
    in_data = V1; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
    wait_rdy(0, "bp");
    step();
    wait_out(0, "bp");
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_vld", 128'(out_valid_w[0]), 128'd1);
      chk("bp_data", out_data_w[0], E1);
      chk("bp_rdy", 128'(in_ready_w[0]), 128'd0);
    end
    out_ready[0] = 1'b1;
    step();                    // single transfer
    in_valid[0] = 1'b0;
    chk("bp_vld_clr", 128'(out_valid_w[0]), 128'd0);
    chk("bp_data_hold", out_data_w[0], E1);
    step();
    chk("bp_no_reaccept", 128'(busy_w[0]), 128'd0);
    chk("bp_vld_low", 128'(out_valid_w[0]), 128'd0);

    // Back-to-back on N=2: second state accepted one cycle after handshake.
    a = rnd128(); b = rnd128();
    in_data = a; fwd_r = 1'b0; in_valid[1] = 1'b1; out_ready[1] = 1'b1;
    wait_rdy(1, "b2b_a");
    step();
    in_data = b;
    wait_out(1, "b2b_a");
    chk("b2b_a_data", out_data_w[1], ref_mix(a, 1'b0));
    step();
    chk("b2b_rdy_next", 128'(in_ready_w[1]), 128'd1);
    step();
    chk("b2b_b_busy", 128'(busy_w[1]), 128'd1);
    chk("b2b_b_rdy_low", 128'(in_ready_w[1]), 128'd0);
    in_valid[1] = 1'b0;
    wait_out(1, "b2b_b");
    chk("b2b_b_data", out_data_w[1], ref_mix(b, 1'b0));
    step();
    chk("b2b_b_vld_clr", 128'(out_valid_w[1]), 128'd0);

    // Reset during the second BUSY cycle of N=1 discards the work.
    in_data = rnd128(); in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    wait_rdy(0, "mid");
    step();                    // accept
    in_valid[0] = 1'b0;
    step();                    // first BUSY edge
    rst_n = 1'b0;
    step();
    chk("mid_vld", 128'(out_valid_w[0]), 128'd0);
    chk("mid_data", out_data_w[0], 128'd0);
    chk("mid_busy", 128'(busy_w[0]), 128'd0);
    rst_n = 1'b1;
    step();
    a = rnd128();
    run_txn(0, a, 1'b0, ref_mix(a, 1'b0), "mid_fresh");

    // Random states across all three widths.
    for (int i = 0; i < 9; i++) begin
      k = i % 3;
      a = rnd128();
      run_txn(k, a, 1'b0, ref_mix(a, 1'b0), "rnd");
    end

`ifdef INV_MIXCOL_FWD_EN
    for (int i = 0; i < 3; i++) run_txn(i, E1, 1'b1, V1, "fwd_vec");
    for (int i = 0; i < 6; i++) begin
      k = i % 3;
      f = 1'($urandom_range(0, 1));
      a = rnd128();
      run_txn(k, a, f, ref_mix(a, f), "fwd_rnd");
    end
    fwd_r = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
